// File: rtl/bird_drawer.sv
// ============================================================================
// Module   : bird_drawer
// Brief    : Erases the bird rectangle at its previous row, then redraws it at
//            the new row, one pixel per cycle towards a 160x120 VGA adapter.
//            Optional macro BIRD_DRAWER_EYE_EN paints a dark eye pixel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bird_drawer #(
  parameter int         BIRD_X      = 30,
  parameter int         BIRD_W      = 4,
  parameter int         BIRD_H      = 4,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] BG_COLOUR   = 3'b011,
  parameter logic [2:0] BIRD_COLOUR = 3'b110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] bird_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] LAST_COL = 4'(BIRD_W - 1);
  localparam logic [3:0] LAST_ROW = 4'(BIRD_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_FIN} state_t;

  state_t     state_q, state_d;
  logic [3:0] col_q, col_d, row_q, row_d;
  logic [7:0] new_y_q, new_y_d, old_y_q, old_y_d;
  logic       old_valid_q, old_valid_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic       w_last, w_pix;
  logic [7:0] w_base;
  logic [8:0] w_row9;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      new_y_q     <= '0;
      old_y_q     <= '0;
      old_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      new_y_q     <= new_y_d;
      old_y_q     <= old_y_d;
      old_valid_q <= old_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Counters track the pixel currently on the outputs; outputs are derived
  // from the next-state values so every output stays a plain register.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    new_y_d     = new_y_q;
    old_y_d     = old_y_q;
    old_valid_d = old_valid_q;
    w_last      = (col_q == LAST_COL) && (row_q == LAST_ROW);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          new_y_d = bird_y;
          col_d   = '0;
          row_d   = '0;
          state_d = old_valid_q ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE, S_DRAW: begin
        if (w_last) begin
          col_d = '0;
          row_d = '0;
          if (state_q == S_ERASE) begin
            state_d = S_DRAW;
          end else begin
            state_d     = S_FIN;
            old_y_d     = new_y_q;
            old_valid_d = 1'b1;
          end
        end else if (col_q == LAST_COL) begin
          col_d = '0;
          row_d = row_q + 4'd1;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    w_pix  = (state_d == S_ERASE) || (state_d == S_DRAW);
    w_base = (state_d == S_ERASE) ? old_y_q : new_y_d;
    w_row9 = {1'b0, w_base} + {5'b0, row_d};

    x_d      = x_q;
    y_d      = y_q;
    colour_d = 3'b000;
    if (w_pix) begin
      x_d = 8'(BIRD_X) + {4'b0, col_d};
      y_d = w_row9[6:0];
    end
    if (state_d == S_ERASE) begin
      colour_d = BG_COLOUR;
    end else if (state_d == S_DRAW) begin
`ifdef BIRD_DRAWER_EYE_EN
      colour_d = ((col_d == LAST_COL) && (row_d == 4'd0)) ? 3'b000 : BIRD_COLOUR;
`else
      colour_d = BIRD_COLOUR;
`endif
    end
    plot_d = w_pix && (w_row9 < 9'(SCREEN_H));
    busy_d = w_pix;
    done_d = (state_d == S_FIN);
  end

  assign x_out  = x_q;
  assign y_out  = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bird_drawer.sv
// ============================================================================
// Module   : tb_bird_drawer
// Brief    : Self-checking bench for bird_drawer against a pixel-list model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bird_drawer;

  localparam int BX = 30, BW = 4, BH = 4, SH = 120;
  localparam logic [2:0] BG = 3'b011, BC = 3'b110;

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0] bird_y = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot, busy, done;

  int errors = 0, checks = 0;

  bird_drawer dut (
    .clk(clk), .reset(reset), .start(start), .bird_y(bird_y),
    .x_out(x_out), .y_out(y_out), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         p;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  bit   m_valid = 0;
  int   m_old_y = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected pixel stream: optional erase pass at the old row, then draw pass.
  function automatic void build(input bit ov, input int oy, input int ny);
    pix_t px;
    int   yy;
    exp_q.delete();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0 && !ov) continue;
      for (int r = 0; r < BH; r++) begin
        for (int c = 0; c < BW; c++) begin
          yy   = ((pass == 0) ? oy : ny) + r;
          px.p = (yy < SH);
          px.x = 8'(BX + c);
          px.y = 7'(yy);
          if (pass == 0) px.c = BG;
`ifdef BIRD_DRAWER_EYE_EN
          else px.c = (c == BW - 1 && r == 0) ? 3'b000 : BC;
`else
          else px.c = BC;
`endif
          exp_q.push_back(px);
        end
      end
    end
  endfunction

  // spam: hold start high and wiggle bird_y throughout; abort_at>0 resets mid-run.
  task automatic redraw(input logic [7:0] ny, input bit spam, input int abort_at);
    int len;
    build(m_valid, m_old_y, int'(ny));
    len = exp_q.size();
    @(negedge clk);
    start  = 1'b1;
    bird_y = ny;
    @(posedge clk);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        reset   = 1'b0;
        start   = 1'b0;
        m_valid = 0;
        m_old_y = 0;
        return;
      end
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("plot", plot, exp_q[k-1].p);
      if (exp_q[k-1].p) begin
        chk("x", x_out, exp_q[k-1].x);
        chk("y", y_out, exp_q[k-1].y);
        chk("colour", colour, exp_q[k-1].c);
      end
      start  = spam;
      bird_y = 8'($urandom);
    end
    @(negedge clk);
    chk("done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_plot", plot, 0);
    m_valid = 1;
    m_old_y = int'(ny);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_plot", plot, 0);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    #12;
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_colour", colour, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    redraw(8'd60, 1'b0, 0);
    redraw(8'd70, 1'b0, 0);
    redraw(8'd118, 1'b0, 0);
    redraw(8'($urandom_range(0, 100)), 1'b1, 0);
    redraw(8'd50, 1'b0, 10);
    redraw(8'd40, 1'b0, 0);
    redraw(8'd50, 1'b0, 0);
    redraw(8'd50, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      redraw(8'($urandom), 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
